cgra_tile_egress: RTL and testbench
===================================

# cgra_tile_egress

Parametrised per-port output stage for a CGRA tile, sitting between the tile's router/PE pair and the mesh output ports. It replaces a fixed "PE result overrides every port" wiring with a per-port runtime mode (off, router, PE broadcast, or shared). Each port has its own buffered PE-broadcast FIFO and full valid/ready back-pressure. Broadcasts are atomic across all selected ports, and two saturating counters report stalls and drops.

## Interface
Parameters:
- DATA_WIDTH, 32, flit/result width
- NUM_PORTS, 4, number of mesh output ports (N/E/S/W order: index 0..3)
- FIFO_DEPTH, 4, PE-broadcast FIFO entries per port; power of two, ≥2
- CNT_WIDTH, 16, width of stall/drop counters

Ports:
- clk  in  1  single clock; everything registered on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_mode  in  2*NUM_PORTS  per-port mode, port i at [2i+1:2i]: 00 OFF, 01 ROUTER, 10 PE, 11 SHARED
- cfg_load  in  1  latch cfg_mode into mode register
- pe_data  in  DATA_WIDTH  PE result
- pe_valid  in  1  PE result valid
- pe_ready  out  1  broadcast accepted this cycle
- rtr_data  in  NUM_PORTS*DATA_WIDTH  router output per port
- rtr_valid  in  NUM_PORTS  router valid per port
- rtr_ready  out  NUM_PORTS  ready back to router per port
- out_data  out  NUM_PORTS*DATA_WIDTH  tile output per port
- out_valid  out  NUM_PORTS  tile output valid per port
- out_ready  in  NUM_PORTS  neighbour ready per port
- stall_cnt  out  CNT_WIDTH  cycles with pe_valid & !pe_ready
- drop_cnt  out  CNT_WIDTH  PE results discarded (no port selected)

## Operation
- mode_q: register, reset all OFF. On cfg_load, mode_q <= cfg_mode.
- bcast_mask[i] = mode_q[i] is PE or SHARED.
- **pe_ready.**
  - When bcast_mask != 0: pe_ready = AND over masked ports of !fifo_full[i].
  - When bcast_mask == 0: pe_ready = 1, and each accepted PE result is discarded (drop_cnt++).
- **Broadcast push.** On pe_valid & pe_ready, pe_data is pushed into every masked FIFO in the same cycle. Push is all-or-nothing; there is never a partial broadcast.
- pe_ready depends only on registered FIFO state, never on out_ready (no combinational ready path).
- **Per-port behaviour by mode:**
  - OFF: out_valid=0, rtr_ready=0, out_data=0.
  - ROUTER: combinational pass-through, out_data=rtr_data, out_valid=rtr_valid, rtr_ready=out_ready. FIFO is not popped.
  - PE: out_data=FIFO head, out_valid=!fifo_empty, rtr_ready=0. Pop on out_valid & out_ready.
  - SHARED: 2-way round-robin between FIFO and router.
    - prio[i] register (0=PE, 1=router), reset 0.
    - Grant goes to the prio source if it is valid, else to the other source.
    - Muxed data/valid are driven from the granted source. rtr_ready = out_ready & grant==router. FIFO pops on a granted transfer.
    - After any completed transfer, prio <= the non-granted source.
- **Simultaneous push and pop on the same FIFO** (only possible when not full): occupancy unchanged, order preserved.
- **Counters.** Both saturate at all-ones and reset to 0.
  - stall_cnt increments each cycle with pe_valid & !pe_ready.
  - drop_cnt increments on each discarded result.
  - cfg_load clears both counters; a clear in the same cycle as an increment takes priority.
- **Mode change.**
  - In the cfg_load cycle, the old mode_q governs all handshakes.
  - At the end of that cycle, FIFOs of ports whose new mode is OFF or ROUTER are flushed, and prio of those ports resets to 0. A push landing in a flushed FIFO that cycle is lost (not counted).
  - FIFOs of ports staying PE/SHARED keep their contents.

## Timing
- Reset values: out_valid=0, out_data=0, rtr_ready=0, pe_ready=1, stall_cnt=0, drop_cnt=0, all FIFOs empty, all prio=0.
- PE→out latency is 1 cycle: a word pushed at edge k is on out_data with out_valid=1 in cycle k+1.
- ROUTER mode: 0-cycle combinational.
- Throughput is one word per port per cycle. A FIFO of depth FIFO_DEPTH sustains full rate under continuous out_ready.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty come from an extra occupancy bit.
- Neighbour rule: out_valid, once high, holds with stable out_data until out_ready.
  - This holds unconditionally in PE mode.
  - In SHARED mode, grant is frozen while out_valid & !out_ready (prio does not move without a transfer).

## Test plan
- **Reset, all OFF.** rst high 2 cycles, then pe_valid=1 pe_data=0xA5 for 3 cycles → pe_ready=1, out_valid=0000, drop_cnt=3.
- **Broadcast to all ports.** All ports PE, out_ready=1111, push 0x11,0x22 → each port shows 0x11 then 0x22 one cycle after each push; stall_cnt=0.
- **Back-pressure.** All ports PE, FIFO_DEPTH=4, out_ready[2]=0, push 6 words → pe_ready drops after word 4; ports 0,1,3 drain all 4 words; stall_cnt counts waiting cycles; no port ever receives word 5 before port 2 frees a slot.
- **SHARED fairness.** Port 1 SHARED, rtr_valid[1]=1 continuous (0xR0..), PE pushing continuously, out_ready=1 → out_data alternates PE, router, PE, router…
- **ROUTER mode.** Port 0 ROUTER → out_data[0]=rtr_data[0] in the same cycle; rtr_ready[0] follows out_ready[0].
- **Mid-run reconfig.** Port 3 PE holding 3 words, cfg_load with port 3 → ROUTER → port 3 FIFO empty next cycle; ports 0..2 contents unchanged; counters 0.

Source files
------------

// File: rtl/cgra_tile_egress_if.sv
// Bundle of the egress stage's configuration, PE, router, mesh-output and counter signals.
// The master side is the tile environment; the slave side is the egress stage itself.
interface cgra_tile_egress_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int CNT_WIDTH  = 16
);
  logic [2*NUM_PORTS-1:0]          cfg_mode;
  logic                            cfg_load;
  logic [DATA_WIDTH-1:0]           pe_data;
  logic                            pe_valid;
  logic                            pe_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rtr_data;
  logic [NUM_PORTS-1:0]            rtr_valid;
  logic [NUM_PORTS-1:0]            rtr_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]            out_valid;
  logic [NUM_PORTS-1:0]            out_ready;
  logic [CNT_WIDTH-1:0]            stall_cnt;
  logic [CNT_WIDTH-1:0]            drop_cnt;

  modport master (
    output cfg_mode, cfg_load, pe_data, pe_valid, rtr_data, rtr_valid, out_ready,
    input  pe_ready, rtr_ready, out_data, out_valid, stall_cnt, drop_cnt
  );

  modport slave (
    input  cfg_mode, cfg_load, pe_data, pe_valid, rtr_data, rtr_valid, out_ready,
    output pe_ready, rtr_ready, out_data, out_valid, stall_cnt, drop_cnt
  );
endinterface

// File: rtl/cgra_tile_egress.sv
// Per-port CGRA tile output stage: each port is OFF, ROUTER pass-through, PE broadcast
// FIFO, or a round-robin SHARED mix; PE broadcasts are atomic across all selected ports.
module cgra_tile_egress #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  cgra_tile_egress_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ROUTER = 2'b01,
    MODE_PE     = 2'b10,
    MODE_SHARED = 2'b11
  } mode_e;

  typedef enum logic {
    SRC_PE  = 1'b0,
    SRC_RTR = 1'b1
  } src_e;

  mode_e                 r_mode    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_mem     [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr    [NUM_PORTS];
  logic [PTR_W-1:0]      r_rptr    [NUM_PORTS];
  logic [PTR_W:0]        r_count   [NUM_PORTS];
  src_e                  r_prio    [NUM_PORTS];
  src_e                  r_lockSrc [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_locked;
  logic [CNT_WIDTH-1:0]  r_stallCnt;
  logic [CNT_WIDTH-1:0]  r_dropCnt;

  logic [NUM_PORTS-1:0]  w_bcast, w_full, w_empty, w_push, w_pop;
  logic [NUM_PORTS-1:0]  w_outValid, w_rtrReady;
  logic [DATA_WIDTH-1:0] w_outData [NUM_PORTS];
  src_e                  w_grant   [NUM_PORTS];
  logic                  w_peReady, w_drop, w_stallEvt;

  // pe_ready looks only at registered occupancy, so it never depends on out_ready.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_bcast[i] = (r_mode[i] == MODE_PE) || (r_mode[i] == MODE_SHARED);
      w_full[i]  = (r_count[i] == (PTR_W+1)'(FIFO_DEPTH));
      w_empty[i] = (r_count[i] == '0);
    end
    w_peReady  = ((w_bcast & w_full) == '0);
    w_push     = {NUM_PORTS{bus.pe_valid & w_peReady}} & w_bcast;
    w_drop     = bus.pe_valid && (w_bcast == '0);
    w_stallEvt = bus.pe_valid && !w_peReady;
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_outData[i]  = '0;
      w_outValid[i] = 1'b0;
      w_rtrReady[i] = 1'b0;
      w_pop[i]      = 1'b0;
      w_grant[i]    = SRC_PE;
      // A stalled SHARED port keeps its previous grant so the offered word stays stable.
      if (r_locked[i])
        w_grant[i] = r_lockSrc[i];
      else if (r_prio[i] == SRC_RTR)
        w_grant[i] = (bus.rtr_valid[i] || w_empty[i]) ? SRC_RTR : SRC_PE;
      else
        w_grant[i] = (w_empty[i] && bus.rtr_valid[i]) ? SRC_RTR : SRC_PE;
      case (r_mode[i])
        MODE_ROUTER: begin
          w_outData[i]  = bus.rtr_data[i*DATA_WIDTH +: DATA_WIDTH];
          w_outValid[i] = bus.rtr_valid[i];
          w_rtrReady[i] = bus.out_ready[i];
        end
        MODE_PE: begin
          w_outValid[i] = !w_empty[i];
          w_outData[i]  = w_empty[i] ? '0 : r_mem[i][r_rptr[i]];
          w_pop[i]      = !w_empty[i] && bus.out_ready[i];
        end
        MODE_SHARED: begin
          if (w_grant[i] == SRC_RTR) begin
            w_outData[i]  = bus.rtr_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_outValid[i] = bus.rtr_valid[i];
            w_rtrReady[i] = bus.out_ready[i];
          end else begin
            w_outValid[i] = !w_empty[i];
            w_outData[i]  = w_empty[i] ? '0 : r_mem[i][r_rptr[i]];
            w_pop[i]      = !w_empty[i] && bus.out_ready[i];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++)
      if (w_push[i]) r_mem[i][r_wptr[i]] <= bus.pe_data;
  end

  // A new mode bit1 of 0 (OFF/ROUTER) flushes that port's FIFO and arbitration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_mode[i]    <= MODE_OFF;
        r_wptr[i]    <= '0;
        r_rptr[i]    <= '0;
        r_count[i]   <= '0;
        r_prio[i]    <= SRC_PE;
        r_lockSrc[i] <= SRC_PE;
      end
      r_locked   <= '0;
      r_stallCnt <= '0;
      r_dropCnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (bus.cfg_load && !bus.cfg_mode[2*i+1]) begin
          r_wptr[i]    <= '0;
          r_rptr[i]    <= '0;
          r_count[i]   <= '0;
          r_prio[i]    <= SRC_PE;
          r_locked[i]  <= 1'b0;
          r_lockSrc[i] <= SRC_PE;
        end else begin
          if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
          if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
          case ({w_push[i], w_pop[i]})
            2'b10:   r_count[i] <= r_count[i] + 1'b1;
            2'b01:   r_count[i] <= r_count[i] - 1'b1;
            default: r_count[i] <= r_count[i];
          endcase
          if (r_mode[i] == MODE_SHARED) begin
            if (w_outValid[i] && bus.out_ready[i])
              r_prio[i] <= (w_grant[i] == SRC_RTR) ? SRC_PE : SRC_RTR;
            r_locked[i]  <= w_outValid[i] && !bus.out_ready[i];
            r_lockSrc[i] <= w_grant[i];
          end else begin
            r_locked[i] <= 1'b0;
          end
        end
        if (bus.cfg_load) r_mode[i] <= mode_e'(bus.cfg_mode[2*i +: 2]);
      end
      if (bus.cfg_load) begin
        r_stallCnt <= '0;
        r_dropCnt  <= '0;
      end else begin
        if (w_stallEvt && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
        if (w_drop && (r_dropCnt != '1))      r_dropCnt  <= r_dropCnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign bus.out_data[g*DATA_WIDTH +: DATA_WIDTH] = w_outData[g];
  end
  assign bus.out_valid = w_outValid;
  assign bus.rtr_ready = w_rtrReady;
  assign bus.pe_ready  = w_peReady;
  assign bus.stall_cnt = r_stallCnt;
  assign bus.drop_cnt  = r_dropCnt;
endmodule

// File: tb/tb_cgra_tile_egress.sv
// Directed self-checking bench for cgra_tile_egress: drop, broadcast, back-pressure,
// SHARED round-robin, ROUTER pass-through and mid-run reconfiguration.
module tb_cgra_tile_egress;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int FD = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  int   testCount = 0;
  int   failCount = 0;
  logic peAcc, rtrAcc;
  logic [31:0] peWord, rtrWord;
  logic [31:0] sharedExp [6] = '{32'hC0, 32'hB0, 32'hC1, 32'hB1, 32'hC2, 32'hB2};

  cgra_tile_egress_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .CNT_WIDTH(CW)) intf ();

  cgra_tile_egress #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic peValid, input logic [31:0] peData, input logic [3:0] outReady);
    intf.pe_valid  = peValid;
    intf.pe_data   = peData;
    intf.out_ready = outReady;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic loadConfig(input logic [7:0] mode);
    intf.cfg_mode = mode;
    intf.cfg_load = 1'b1;
    nextCycle();
    intf.cfg_load = 1'b0;
  endtask

  function automatic logic [31:0] portData(input int p);
    return intf.out_data[p*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1;
    intf.cfg_mode  = '0;
    intf.cfg_load  = 1'b0;
    intf.rtr_data  = '0;
    intf.rtr_valid = '0;
    applyStimulus(1'b0, 32'h0, 4'h0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", intf.out_valid, 0);
    checkOutput("reset_out_data", intf.out_data, 0);
    checkOutput("reset_rtr_ready", intf.rtr_ready, 0);
    checkOutput("reset_pe_ready", intf.pe_ready, 1);
    checkOutput("reset_stall", intf.stall_cnt, 0);
    checkOutput("reset_drop", intf.drop_cnt, 0);

    // All ports OFF: every PE result is accepted and discarded.
    applyStimulus(1'b1, 32'hA5, 4'h0);
    #1 checkOutput("off_pe_ready", intf.pe_ready, 1);
    nextCycle();
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'h0);
    #1;
    checkOutput("off_drop_cnt", intf.drop_cnt, 3);
    checkOutput("off_out_valid", intf.out_valid, 0);

    // Broadcast to all four ports.
    loadConfig(8'hAA);
    #1 checkOutput("cfg_clears_drop", intf.drop_cnt, 0);
    applyStimulus(1'b1, 32'h11, 4'hF);
    #1 checkOutput("bc_pe_ready", intf.pe_ready, 1);
    nextCycle();
    applyStimulus(1'b1, 32'h22, 4'hF);
    #1;
    checkOutput("bc_valid_1", intf.out_valid, 4'hF);
    checkOutput("bc_data_11", intf.out_data, {4{32'h11}});
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'hF);
    #1;
    checkOutput("bc_valid_2", intf.out_valid, 4'hF);
    checkOutput("bc_data_22", intf.out_data, {4{32'h22}});
    nextCycle();
    #1;
    checkOutput("bc_drained", intf.out_valid, 0);
    checkOutput("bc_stall", intf.stall_cnt, 0);

    // Back-pressure from port 2 with words 0x101..0x106.
    applyStimulus(1'b1, 32'h101, 4'b1011);
    #1 checkOutput("bp_ready_w1", intf.pe_ready, 1);
    for (int k = 2; k <= 4; k++) begin
      nextCycle();
      applyStimulus(1'b1, 32'h100 + k, 4'b1011);
      #1;
      checkOutput($sformatf("bp_ready_w%0d", k), intf.pe_ready, 1);
      checkOutput($sformatf("bp_p0_w%0d", k-1), portData(0), 32'h100 + k - 1);
      checkOutput($sformatf("bp_p2_head_%0d", k), portData(2), 32'h101);
    end
    nextCycle();
    applyStimulus(1'b1, 32'h105, 4'b1011);
    #1;
    checkOutput("bp_ready_drop", intf.pe_ready, 0);
    checkOutput("bp_p0_w4", portData(0), 32'h104);
    checkOutput("bp_p3_w4", portData(3), 32'h104);
    nextCycle();
    #1;
    checkOutput("bp_still_stalled", intf.pe_ready, 0);
    checkOutput("bp_no_w5_leak", intf.out_valid, 4'b0100);
    checkOutput("bp_p2_hold", portData(2), 32'h101);
    nextCycle();
    #1 checkOutput("bp_stall_2", intf.stall_cnt, 2);
    applyStimulus(1'b1, 32'h105, 4'hF);
    #1 checkOutput("bp_ready_registered", intf.pe_ready, 0);
    nextCycle();
    #1;
    checkOutput("bp_stall_3", intf.stall_cnt, 3);
    checkOutput("bp_ready_back", intf.pe_ready, 1);
    checkOutput("bp_valid_c7", intf.out_valid, 4'b0100);
    checkOutput("bp_p2_w2", portData(2), 32'h102);
    nextCycle();
    applyStimulus(1'b1, 32'h106, 4'hF);
    #1;
    checkOutput("bp_p0_w5", portData(0), 32'h105);
    checkOutput("bp_p2_w3", portData(2), 32'h103);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'hF);
    #1;
    checkOutput("bp_p0_w6", portData(0), 32'h106);
    checkOutput("bp_p2_w4", portData(2), 32'h104);
    nextCycle();
    #1;
    checkOutput("bp_valid_c10", intf.out_valid, 4'b0100);
    checkOutput("bp_p2_w5", portData(2), 32'h105);
    nextCycle();
    #1 checkOutput("bp_p2_w6", portData(2), 32'h106);
    nextCycle();
    #1;
    checkOutput("bp_all_drained", intf.out_valid, 0);
    checkOutput("bp_stall_final", intf.stall_cnt, 3);

    // Port 1 SHARED: PE and router alternate once both are offering data.
    loadConfig(8'h0C);
    #1 checkOutput("sh_cfg_clears_stall", intf.stall_cnt, 0);
    peWord  = 32'hC0;
    rtrWord = 32'hB0;
    applyStimulus(1'b1, peWord, 4'hF);
    #1;
    checkOutput("sh_idle", intf.out_valid, 0);
    peAcc  = intf.pe_valid & intf.pe_ready;
    rtrAcc = intf.rtr_valid[1] & intf.rtr_ready[1];
    for (int n = 0; n < 6; n++) begin
      nextCycle();
      if (peAcc)  peWord++;
      if (rtrAcc) rtrWord++;
      applyStimulus(1'b1, peWord, 4'hF);
      intf.rtr_valid = 4'b0010;
      intf.rtr_data  = {32'h0, 32'h0, rtrWord, 32'h0};
      #1;
      checkOutput($sformatf("sh_data_%0d", n), portData(1), sharedExp[n]);
      checkOutput($sformatf("sh_rtr_ready_%0d", n), intf.rtr_ready, (n % 2 == 1) ? 4'b0010 : 4'b0000);
      peAcc  = intf.pe_valid & intf.pe_ready;
      rtrAcc = intf.rtr_valid[1] & intf.rtr_ready[1];
    end
    nextCycle();
    if (rtrAcc) rtrWord++;
    applyStimulus(1'b0, 32'h0, 4'b1101);
    intf.rtr_data = {32'h0, 32'h0, rtrWord, 32'h0};
    #1;
    checkOutput("sh_stall_data", portData(1), 32'hC3);
    checkOutput("sh_stall_rtr_ready", intf.rtr_ready, 0);
    nextCycle();
    #1 checkOutput("sh_stall_hold", portData(1), 32'hC3);
    applyStimulus(1'b0, 32'h0, 4'hF);
    #1 checkOutput("sh_release", portData(1), 32'hC3);
    nextCycle();
    #1;
    checkOutput("sh_after_release", portData(1), 32'hB3);
    checkOutput("sh_after_rtr_ready", intf.rtr_ready, 4'b0010);
    intf.rtr_valid = 4'b0000;

    // Port 0 ROUTER: combinational pass-through; no broadcast target so PE results drop.
    loadConfig(8'h01);
    intf.rtr_data  = {96'h0, 32'hDEADBEEF};
    intf.rtr_valid = 4'b0001;
    applyStimulus(1'b1, 32'h77, 4'b0001);
    #1;
    checkOutput("rt_data", portData(0), 32'hDEADBEEF);
    checkOutput("rt_valid", intf.out_valid, 4'b0001);
    checkOutput("rt_ready", intf.rtr_ready, 4'b0001);
    intf.out_ready = 4'b0000;
    #1;
    checkOutput("rt_ready_follow", intf.rtr_ready, 4'b0000);
    checkOutput("rt_valid_held", intf.out_valid, 4'b0001);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'h0);
    intf.rtr_valid = 4'b0000;
    #1 checkOutput("rt_drop_cnt", intf.drop_cnt, 2);

    // Mid-run reconfiguration: port 3 leaves PE mode while holding three words.
    loadConfig(8'hAA);
    applyStimulus(1'b1, 32'hD1, 4'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hD2, 4'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hD3, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'h0);
    #1;
    checkOutput("rc_valid_before", intf.out_valid, 4'hF);
    checkOutput("rc_p3_before", portData(3), 32'hD1);
    loadConfig(8'h6A);
    #1;
    checkOutput("rc_valid_after", intf.out_valid, 4'b0111);
    checkOutput("rc_p2_kept", portData(2), 32'hD1);
    checkOutput("rc_stall", intf.stall_cnt, 0);
    checkOutput("rc_drop", intf.drop_cnt, 0);
    loadConfig(8'hAA);
    #1 checkOutput("rc_p3_flushed", intf.out_valid, 4'b0111);
    applyStimulus(1'b0, 32'h0, 4'b0001);
    #1 checkOutput("rc_p0_d1", portData(0), 32'hD1);
    nextCycle();
    #1 checkOutput("rc_p0_d2", portData(0), 32'hD2);
    nextCycle();
    #1 checkOutput("rc_p0_d3", portData(0), 32'hD3);
    nextCycle();
    #1 checkOutput("rc_p0_empty", intf.out_valid, 4'b0110);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
